// File: rtl/sseg_word_scheduler.sv
// rtl/sseg_word_scheduler.sv - two-requester arbiter and scan scheduler for a 4-digit 7-seg display
//
// Grants one requester at a time, keeps the granted word on the display for
// HOLD_SCANS scan ticks, then blanks the display for GAP_SCANS scan ticks.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   REQ0, WORD0      high-priority requester: level request and 2-bit word code
//   REQ1, WORD1      low-priority requester: level request and 2-bit word code
//   GNT0, GNT1       one-cycle grant pulses (word latched on the same edge)
//   DONE             one-cycle pulse on the last cycle of SHOW
//   BUSY             high in SHOW and GAP
//   WORD_SEL         latched word code to the decoder
//   DIG_SEL          current digit index 0..3 to the decoder
//   DISP_EN          active-low anode enables, one-hot-low in SHOW only

module sseg_word_scheduler #(
    parameter int SCAN_DIV   = 2200,
    parameter int HOLD_SCANS = 1024,
    parameter int GAP_SCANS  = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic [1:0] WORD0,
    input  logic       REQ1,
    input  logic [1:0] WORD1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       DONE,
    output logic       BUSY,
    output logic [1:0] WORD_SEL,
    output logic [1:0] DIG_SEL,
    output logic [3:0] DISP_EN
);

    localparam int PW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int HW = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS) : 1;
    localparam int GW = (GAP_SCANS > 1)  ? $clog2(GAP_SCANS)  : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SCANS - 1);
    localparam logic [GW-1:0] GAP_LAST  = (GAP_SCANS > 0) ? GW'(GAP_SCANS - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] prescaler;
    logic [1:0]    dig_sel;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic [1:0]    word_q;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          fair;

    logic tick;
    logic grant;
    logic pick0;
    logic pick1;
    logic hold_last;
    logic gap_last;

    assign tick      = (prescaler == PRE_LAST);
    assign hold_last = tick && (hold_cnt == HOLD_LAST);
    assign gap_last  = tick && (gap_cnt == GAP_LAST);

    // REQ1 overrides REQ0 only when REQ0 already took a word while REQ1 waited.
    assign pick1 = REQ1 && (fair || !REQ0);
    assign pick0 = REQ0 && !pick1;
    assign grant = (state == S_IDLE) && (REQ0 || REQ1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    next_state = S_SHOW;
                end
            end
            S_SHOW: begin
                if (hold_last) begin
                    next_state = (GAP_SCANS == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler <= '0;
            dig_sel   <= '0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            word_q    <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            fair      <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) begin
                dig_sel <= dig_sel + 2'd1;
            end

            gnt0_q <= grant && pick0;
            gnt1_q <= grant && pick1;

            if (grant) begin
                word_q   <= pick1 ? WORD1 : WORD0;
                hold_cnt <= '0;
            end else if (state == S_SHOW && tick) begin
                hold_cnt <= hold_cnt + HW'(1);
            end

            if (state == S_SHOW && hold_last) begin
                gap_cnt <= '0;
            end else if (state == S_GAP && tick) begin
                gap_cnt <= gap_cnt + GW'(1);
            end

            if (grant && pick1) begin
                fair <= 1'b0;
            end else if (grant && pick0 && REQ1) begin
                fair <= 1'b1;
            end
        end
    end

    always_comb begin
        GNT0     = gnt0_q;
        GNT1     = gnt1_q;
        WORD_SEL = word_q;
        DIG_SEL  = dig_sel;
        BUSY     = (state != S_IDLE);
        DONE     = (state == S_SHOW) && hold_last;
        DISP_EN  = (state == S_SHOW) ? ~(4'b0001 << dig_sel) : 4'b1111;
    end

endmodule

// File: tb/tb_sseg_word_scheduler.sv
// tb/tb_sseg_word_scheduler.sv - self-checking bench for sseg_word_scheduler

module tb_sseg_word_scheduler;

    localparam int SD = 4;
    localparam int HS = 8;
    localparam int GS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0;
    logic       req1;
    logic [1:0] word0;
    logic [1:0] word1;

    logic       o_g0   [2];
    logic       o_g1   [2];
    logic       o_done [2];
    logic       o_busy [2];
    logic [1:0] o_ws   [2];
    logic [1:0] o_dig  [2];
    logic [3:0] o_en   [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sseg_word_scheduler #(.SCAN_DIV(SD), .HOLD_SCANS(HS), .GAP_SCANS(GS)) dut_gap (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .WORD0(word0), .REQ1(req1), .WORD1(word1),
        .GNT0(o_g0[0]), .GNT1(o_g1[0]), .DONE(o_done[0]), .BUSY(o_busy[0]),
        .WORD_SEL(o_ws[0]), .DIG_SEL(o_dig[0]), .DISP_EN(o_en[0])
    );

    sseg_word_scheduler #(.SCAN_DIV(SD), .HOLD_SCANS(HS), .GAP_SCANS(0)) dut_nogap (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .WORD0(word0), .REQ1(req1), .WORD1(word1),
        .GNT0(o_g0[1]), .GNT1(o_g1[1]), .DONE(o_done[1]), .BUSY(o_busy[1]),
        .WORD_SEL(o_ws[1]), .DIG_SEL(o_dig[1]), .DISP_EN(o_en[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycle c counts clock edges since the last reset edge.
    // A grant schedules the whole word as absolute cycle numbers: the cycle of
    // DONE and the first cycle back in IDLE.
    int         c;
    int         m_done [2];
    int         m_idle [2];
    bit         m_fair [2];
    logic [1:0] m_word [2];
    bit         m_g0   [2];
    bit         m_g1   [2];

    always @(posedge clk) begin
        if (rst) begin
            c = 0;
            for (int k = 0; k < 2; k++) begin
                m_done[k] = -1; m_idle[k] = 0; m_fair[k] = 0;
                m_word[k] = 2'd0; m_g0[k] = 0; m_g1[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int g, t0, gap;
                gap = (k == 0) ? GS : 0;
                m_g0[k] = 0;
                m_g1[k] = 0;
                if (c >= m_idle[k] && (req0 || req1)) begin
                    g  = c + 1;
                    t0 = g + (SD - 1 - (g % SD));
                    m_done[k] = t0 + (HS - 1) * SD;
                    m_idle[k] = m_done[k] + gap * SD + 1;
                    if (req1 && (m_fair[k] || !req0)) begin
                        m_g1[k] = 1; m_word[k] = word1; m_fair[k] = 0;
                    end else begin
                        m_g0[k] = 1; m_word[k] = word0;
                        if (req1) m_fair[k] = 1;
                    end
                end
            end
            c = c + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [1:0] e_dig;
            bit         e_show;
            e_dig  = 2'((c / SD) % 4);
            e_show = (c <= m_done[k]);
            check($sformatf("m%0d_dig c=%0d", k, c), 32'(o_dig[k]), 32'(e_dig));
            check($sformatf("m%0d_busy c=%0d", k, c), 32'(o_busy[k]), 32'(c < m_idle[k]));
            check($sformatf("m%0d_done c=%0d", k, c), 32'(o_done[k]), 32'(c == m_done[k]));
            check($sformatf("m%0d_en c=%0d", k, c), 32'(o_en[k]),
                  e_show ? 32'(~(4'b0001 << e_dig) & 4'hF) : 32'hF);
            check($sformatf("m%0d_gnt0 c=%0d", k, c), 32'(o_g0[k]), 32'(m_g0[k]));
            check($sformatf("m%0d_gnt1 c=%0d", k, c), 32'(o_g1[k]), 32'(m_g1[k]));
            check($sformatf("m%0d_word c=%0d", k, c), 32'(o_ws[k]), 32'(m_word[k]));
        end
    end

    typedef struct {
        bit         r0;
        bit         r1;
        logic [1:0] w0;
        logic [1:0] w1;
        bit         e_g0;
        bit         e_g1;
        logic [1:0] e_word;
        bit         e_busy;
    } vec_t;

    vec_t tbl[8];

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((o_busy[0] || o_busy[1]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(o_busy[0] || o_busy[1]), 32'd0);
    endtask

    task automatic post();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int         exp_dig[5];
        int         at_k[5];
        int         gid[4];
        logic [1:0] gw[4];
        int         ng;
        int         n;
        bit         quiet;
        bit         early;
        logic [1:0] last_dig;
        int         steps;

        rst = 1'b1; req0 = 0; req1 = 0; word0 = 0; word1 = 0;

        tbl[0] = '{1, 0, 2'd1, 2'd0, 1, 0, 2'd1, 1};
        tbl[1] = '{1, 1, 2'd2, 2'd3, 1, 0, 2'd2, 1};
        tbl[2] = '{1, 1, 2'd2, 2'd3, 0, 1, 2'd3, 1};
        tbl[3] = '{0, 1, 2'd0, 2'd1, 0, 1, 2'd1, 1};
        tbl[4] = '{1, 1, 2'd0, 2'd2, 1, 0, 2'd0, 1};
        tbl[5] = '{1, 0, 2'd3, 2'd1, 1, 0, 2'd3, 1};
        tbl[6] = '{1, 1, 2'd1, 2'd2, 0, 1, 2'd2, 1};
        tbl[7] = '{0, 0, 2'd3, 2'd3, 0, 0, 2'd2, 0};

        // Reset for three edges, then idle scanning with no requests.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_dig = '{0, 1, 2, 3, 0};
        at_k    = '{3, 4, 8, 12, 16};
        quiet = 1;
        for (int k = 1; k <= 16; k++) begin
            post();
            if (o_g0[0] || o_g1[0] || o_done[0] || o_busy[0] || o_en[0] != 4'hF) quiet = 0;
            for (int i = 0; i < 5; i++)
                if (at_k[i] == k) check($sformatf("idle_dig k=%0d", k), 32'(o_dig[0]), 32'(exp_dig[i]));
        end
        check("idle_quiet", 32'(quiet), 32'd1);

        // Table of single grants from IDLE, including fairness history.
        for (int i = 0; i < 8; i++) begin
            wait_idle();
            req0 = tbl[i].r0; req1 = tbl[i].r1; word0 = tbl[i].w0; word1 = tbl[i].w1;
            post();
            check($sformatf("tbl%0d_gnt0", i), 32'(o_g0[0]), 32'(tbl[i].e_g0));
            check($sformatf("tbl%0d_gnt1", i), 32'(o_g1[0]), 32'(tbl[i].e_g1));
            check($sformatf("tbl%0d_word", i), 32'(o_ws[0]), 32'(tbl[i].e_word));
            check($sformatf("tbl%0d_busy", i), 32'(o_busy[0]), 32'(tbl[i].e_busy));
            @(negedge clk);
            req0 = 0; req1 = 0;
        end

        // Both requesters held: grants must alternate.
        wait_idle();
        req0 = 1; req1 = 1; word0 = 2'd2; word1 = 2'd3;
        ng = 0; n = 0;
        while (ng < 4 && n < 400) begin
            post();
            if (o_g0[0] || o_g1[0]) begin
                gid[ng] = o_g1[0] ? 1 : 0;
                gw[ng]  = o_ws[0];
                ng++;
            end
            n++;
        end
        check("alt_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) begin
            check($sformatf("alt_id%0d", i), 32'(gid[i]), 32'(i % 2));
            check($sformatf("alt_word%0d", i), 32'(gw[i]), (i % 2 == 0) ? 32'd2 : 32'd3);
        end
        @(negedge clk);
        req0 = 0; req1 = 0;

        // REQ1 arrives mid-SHOW: waits for GAP to end, WORD1 sampled on grant cycle.
        wait_idle();
        req0 = 1; word0 = 2'd1;
        @(negedge clk);
        req0 = 0;
        repeat (10) @(negedge clk);
        req1 = 1; word1 = 2'd0;
        early = 0; n = 0;
        while (o_busy[0] && n < 200) begin
            if (o_g1[0]) early = 1;
            @(negedge clk);
            n++;
        end
        check("late_no_early_gnt1", 32'(early), 32'd0);
        check("late_idle_gnt1", 32'(o_g1[0]), 32'd0);
        word1 = 2'd2;
        post();
        check("late_gnt1", 32'(o_g1[0]), 32'd1);
        check("late_word", 32'(o_ws[0]), 32'd2);
        @(negedge clk);
        req1 = 0;

        // Reset in the middle of SHOW, with REQ0 pending across the reset.
        wait_idle();
        req0 = 1; word0 = 2'd3;
        @(negedge clk);
        req0 = 0;
        last_dig = o_dig[0];
        steps = 0; n = 0;
        while (steps < 4 && n < 40) begin
            @(negedge clk);
            if (o_dig[0] != last_dig) steps++;
            last_dig = o_dig[0];
            n++;
        end
        check("rst_mid_show_busy_before", 32'(o_busy[0]), 32'd1);
        rst = 1; req0 = 1; word0 = 2'd1;
        post();
        check("rst_busy", 32'(o_busy[0]), 32'd0);
        check("rst_en", 32'(o_en[0]), 32'hF);
        check("rst_done", 32'(o_done[0]), 32'd0);
        check("rst_gnt0", 32'(o_g0[0]), 32'd0);
        @(negedge clk);
        rst = 0;
        post();
        check("rst_regrant", 32'(o_g0[0]), 32'd1);
        check("rst_regrant_word", 32'(o_ws[0]), 32'd1);
        @(negedge clk);
        req0 = 0;

        // No-gap instance: DONE is followed by one IDLE cycle, then the next grant.
        wait_idle();
        req0 = 1; word0 = 2'd2;
        n = 0;
        post();
        while (!o_done[1] && n < 100) begin
            post();
            n++;
        end
        check("nogap_done_seen", 32'(o_done[1]), 32'd1);
        post();
        check("nogap_idle_busy", 32'(o_busy[1]), 32'd0);
        check("nogap_idle_gnt", 32'(o_g0[1]), 32'd0);
        post();
        check("nogap_regrant", 32'(o_g0[1]), 32'd1);
        check("nogap_regrant_busy", 32'(o_busy[1]), 32'd1);
        @(negedge clk);
        req0 = 0;

        // Random traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 499) == 0);
            req0  = ($urandom_range(0, 3) == 0);
            req1  = ($urandom_range(0, 2) == 0);
            word0 = 2'($urandom_range(0, 3));
            word1 = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 0; req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
